// File: rtl/enoc_network_interface.sv
// enoc_network_interface: router port-0 endpoint with injection/ejection FIFOs and packet counters.
// Define ENOC_NI_DEST_CHECK_EN to drop ejected packets whose dest differs from LOC and flag o_dest_err.
package enoc_pkg;
    typedef struct packed {
        logic [7:0]  dest;
        logic [23:0] payload;
    } packet_t;
endpackage

module enoc_ni_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign rdata = mem[rd_ptr];
    // explicit wrap compare keeps non-power-of-2 depths in range
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end
endmodule

module enoc_network_interface
    import enoc_pkg::*;
#(
    parameter int INJECT_DEPTH = 4,
    parameter int EJECT_DEPTH = 4,
    parameter int LOC = 0,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  packet_t          i_core_data,
    input  logic             i_core_val,
    output logic             o_core_en,
    output packet_t          o_net_data,
    output logic             o_net_data_val,
    input  logic             i_net_en,
    input  packet_t          i_net_data,
    input  logic             i_net_data_val,
    output logic             o_net_en,
    output packet_t          o_core_data,
    output logic             o_core_val,
    input  logic             i_core_en,
    output logic [CNT_W-1:0] o_inject_cnt,
    output logic [CNT_W-1:0] o_eject_cnt,
    output logic             o_dest_err
);
    localparam int PW = $bits(packet_t);
    logic inj_full, inj_empty, inj_push, inj_pop;
    logic ej_full, ej_empty, ej_accept, ej_push, ej_pop;
    logic dest_ok;
    logic [PW-1:0] inj_head, ej_head;

    assign o_core_en = ~reset & ~inj_full;
    assign inj_push = i_core_val & o_core_en;
    assign o_net_data_val = ~reset & ~inj_empty & i_net_en;
    assign inj_pop = o_net_data_val;
    assign o_net_data = reset ? '0 : packet_t'(inj_head);

    assign o_net_en = ~reset & ~ej_full;
    assign ej_accept = i_net_data_val & o_net_en;
    assign ej_push = ej_accept & dest_ok;
    assign o_core_val = ~reset & ~ej_empty;
    assign ej_pop = o_core_val & i_core_en;
    assign o_core_data = reset ? '0 : packet_t'(ej_head);

    enoc_ni_fifo #(.DEPTH(INJECT_DEPTH), .W(PW)) u_inj (
        .clk(clk),
        .reset(reset),
        .push(inj_push),
        .wdata(i_core_data),
        .pop(inj_pop),
        .rdata(inj_head),
        .full(inj_full),
        .empty(inj_empty)
    );

    enoc_ni_fifo #(.DEPTH(EJECT_DEPTH), .W(PW)) u_ej (
        .clk(clk),
        .reset(reset),
        .push(ej_push),
        .wdata(i_net_data),
        .pop(ej_pop),
        .rdata(ej_head),
        .full(ej_full),
        .empty(ej_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_inject_cnt <= '0;
            o_eject_cnt <= '0;
        end else begin
            if (inj_pop) o_inject_cnt <= o_inject_cnt + CNT_W'(1);
            if (ej_pop) o_eject_cnt <= o_eject_cnt + CNT_W'(1);
        end
    end

`ifdef ENOC_NI_DEST_CHECK_EN
    logic dest_err;
    assign dest_ok = i_net_data.dest == 8'(LOC);
    assign o_dest_err = dest_err;
    // misrouted packets still complete the link handshake, they are just not stored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) dest_err <= 1'b0;
        else if (ej_accept & ~dest_ok) dest_err <= 1'b1;
    end
`else
    logic unused_loc;
    assign unused_loc = |LOC;
    assign dest_ok = 1'b1;
    assign o_dest_err = 1'b0;
`endif
endmodule

// File: tb/tb_enoc_network_interface.sv
// tb_enoc_network_interface: directed checks of injection, ejection, flow control, counters and reset.
module tb_enoc_network_interface;
    import enoc_pkg::*;
`ifdef ENOC_NI_DEST_CHECK_EN
    localparam int LOC = 3;
`else
    localparam int LOC = 0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    packet_t i_core_data = '0;
    packet_t i_net_data = '0;
    packet_t o_net_data, o_core_data;
    logic i_core_val = 1'b0, i_net_en = 1'b0, i_net_data_val = 1'b0, i_core_en = 1'b0;
    logic o_core_en, o_net_data_val, o_net_en, o_core_val, o_dest_err;
    logic [31:0] o_inject_cnt, o_eject_cnt;
    logic [31:0] exp_inj = '0, exp_ej = '0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    enoc_network_interface #(.INJECT_DEPTH(4), .EJECT_DEPTH(4), .LOC(LOC), .CNT_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .i_core_data(i_core_data),
        .i_core_val(i_core_val),
        .o_core_en(o_core_en),
        .o_net_data(o_net_data),
        .o_net_data_val(o_net_data_val),
        .i_net_en(i_net_en),
        .i_net_data(i_net_data),
        .i_net_data_val(i_net_data_val),
        .o_net_en(o_net_en),
        .o_core_data(o_core_data),
        .o_core_val(o_core_val),
        .i_core_en(i_core_en),
        .o_inject_cnt(o_inject_cnt),
        .o_eject_cnt(o_eject_cnt),
        .o_dest_err(o_dest_err)
    );

    function automatic packet_t pk(input int d, input int p);
        return packet_t'{dest: 8'(d), payload: 24'(p)};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if ({o_core_en, o_net_en, o_net_data_val, o_core_val, o_dest_err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b want 00000", {o_core_en, o_net_en, o_net_data_val, o_core_val, o_dest_err});
        end
        tests++;
        if (o_inject_cnt !== 32'd0 || o_eject_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", o_inject_cnt, o_eject_cnt);
        end
        tests++;
        if (o_net_data !== '0 || o_core_data !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h/%h want 0/0", o_net_data, o_core_data);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (o_core_en !== 1'b1 || o_net_en !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_en: got %b%b want 11", o_core_en, o_net_en);
        end
    endtask

    task automatic test_inject_order();
        i_net_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            i_core_val = k < 3;
            i_core_data = pk(5 + k, 100 + k);
            #1;
            tests++;
            if (k >= 1 && k <= 3) begin
                if (o_net_data_val !== 1'b1 || o_net_data !== pk(4 + k, 99 + k)) begin
                    fails++;
                    $display("FAIL inj_order[%0d]: got val=%b data=%h want val=1 data=%h", k, o_net_data_val, o_net_data, pk(4 + k, 99 + k));
                end
            end else if (o_net_data_val !== 1'b0) begin
                fails++;
                $display("FAIL inj_order_idle[%0d]: got val=%b want 0", k, o_net_data_val);
            end
        end
        exp_inj += 3;
        tests++;
        if (o_inject_cnt !== exp_inj) begin
            fails++;
            $display("FAIL inj_order_cnt: got %0d want %0d", o_inject_cnt, exp_inj);
        end
        i_core_val = 1'b0;
    endtask

    task automatic test_inject_full();
        i_net_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            i_core_val = 1'b1;
            i_core_data = pk(10 + k, 200 + k);
            #1;
            tests++;
            if (o_core_en !== (k < 4) || o_net_data_val !== 1'b0) begin
                fails++;
                $display("FAIL inj_full[%0d]: got en=%b val=%b want en=%b val=0", k, o_core_en, o_net_data_val, k < 4);
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                i_core_val = 1'b0;
                i_net_en = 1'b1;
            end
            #1;
            tests++;
            if (k < 4 && (o_net_data_val !== 1'b1 || o_net_data !== pk(10 + k, 200 + k))) begin
                fails++;
                $display("FAIL inj_drain[%0d]: got val=%b data=%h want val=1 data=%h", k, o_net_data_val, o_net_data, pk(10 + k, 200 + k));
            end else if (k == 4 && o_net_data_val !== 1'b0) begin
                fails++;
                $display("FAIL inj_drain_extra: got val=%b want 0", o_net_data_val);
            end
        end
        exp_inj += 4;
        tests++;
        if (o_inject_cnt !== exp_inj) begin
            fails++;
            $display("FAIL inj_full_cnt: got %0d want %0d", o_inject_cnt, exp_inj);
        end
    endtask

    task automatic test_eject_full();
        i_core_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i_net_data_val = 1'b1;
            i_net_data = pk(LOC, 300 + k);
            #1;
            tests++;
            if (o_net_en !== 1'b1) begin
                fails++;
                $display("FAIL ej_fill[%0d]: got en=%b want 1", k, o_net_en);
            end
        end
        @(negedge clk);
        i_net_data_val = 1'b0;
        #1;
        tests++;
        if (o_net_en !== 1'b0 || o_core_val !== 1'b1 || o_core_data !== pk(LOC, 300)) begin
            fails++;
            $display("FAIL ej_full: got en=%b val=%b data=%h want en=0 val=1 data=%h", o_net_en, o_core_val, o_core_data, pk(LOC, 300));
        end
        i_core_en = 1'b1;
        i_net_data_val = 1'b1;
        i_net_data = pk(LOC, 999);
        #1;
        tests++;
        if (o_net_en !== 1'b0) begin
            fails++;
            $display("FAIL ej_no_write_through: got en=%b want 0", o_net_en);
        end
        @(negedge clk);
        i_core_en = 1'b0;
        i_net_data_val = 1'b0;
        #1;
        exp_ej += 1;
        tests++;
        if (o_net_en !== 1'b1 || o_core_data !== pk(LOC, 301) || o_eject_cnt !== exp_ej) begin
            fails++;
            $display("FAIL ej_one_pop: got en=%b data=%h cnt=%0d want en=1 data=%h cnt=%0d", o_net_en, o_core_data, o_eject_cnt, pk(LOC, 301), exp_ej);
        end
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            i_core_en = k < 4;
            #1;
            tests++;
            if (k < 4 && (o_core_val !== 1'b1 || o_core_data !== pk(LOC, 300 + k))) begin
                fails++;
                $display("FAIL ej_drain[%0d]: got val=%b data=%h want val=1 data=%h", k, o_core_val, o_core_data, pk(LOC, 300 + k));
            end else if (k == 4 && o_core_val !== 1'b0) begin
                fails++;
                $display("FAIL ej_drain_extra: got val=%b want 0", o_core_val);
            end
        end
        exp_ej += 3;
        tests++;
        if (o_eject_cnt !== exp_ej) begin
            fails++;
            $display("FAIL ej_cnt: got %0d want %0d", o_eject_cnt, exp_ej);
        end
    endtask

    task automatic test_back_to_back();
        i_net_en = 1'b0;
        i_core_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            i_core_val = 1'b1;
            i_core_data = pk(30 + k, 500 + k);
            i_net_data_val = 1'b1;
            i_net_data = pk(LOC, 400 + k);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            i_core_data = pk(32 + i, 502 + i);
            i_net_data = pk(LOC, 402 + i);
            i_net_en = 1'b1;
            i_core_en = 1'b1;
            #1;
            tests++;
            if (o_core_en !== 1'b1 || o_net_en !== 1'b1 ||
                o_net_data_val !== 1'b1 || o_net_data !== pk(30 + i, 500 + i) ||
                o_core_val !== 1'b1 || o_core_data !== pk(LOC, 400 + i)) begin
                fails++;
                $display("FAIL b2b[%0d]: got en=%b%b net=%b/%h core=%b/%h want en=11 net=1/%h core=1/%h", i, o_core_en, o_net_en,
                         o_net_data_val, o_net_data, o_core_val, o_core_data, pk(30 + i, 500 + i), pk(LOC, 400 + i));
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i_core_val = 1'b0;
            i_net_data_val = 1'b0;
            i_net_en = k < 2;
            i_core_en = k < 2;
            #1;
            if (k == 0) begin
                exp_inj += 10;
                exp_ej += 10;
                tests++;
                if (o_inject_cnt !== exp_inj || o_eject_cnt !== exp_ej) begin
                    fails++;
                    $display("FAIL b2b_cnt: got %0d/%0d want %0d/%0d", o_inject_cnt, o_eject_cnt, exp_inj, exp_ej);
                end
            end
            tests++;
            if (k < 2 && (o_net_data_val !== 1'b1 || o_net_data !== pk(40 + k, 510 + k) ||
                          o_core_val !== 1'b1 || o_core_data !== pk(LOC, 410 + k))) begin
                fails++;
                $display("FAIL b2b_tail[%0d]: got net=%b/%h core=%b/%h want net=1/%h core=1/%h", k, o_net_data_val, o_net_data,
                         o_core_val, o_core_data, pk(40 + k, 510 + k), pk(LOC, 410 + k));
            end else if (k == 2 && (o_net_data_val !== 1'b0 || o_core_val !== 1'b0)) begin
                fails++;
                $display("FAIL b2b_occupancy: got vals=%b%b want 00", o_net_data_val, o_core_val);
            end
        end
        exp_inj += 2;
        exp_ej += 2;
    endtask

    task automatic test_reset_mid();
        i_net_en = 1'b0;
        i_core_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i_core_val = 1'b1;
            i_core_data = pk(60 + k, 600 + k);
            i_net_data_val = 1'b1;
            i_net_data = pk(LOC, 700 + k);
        end
        @(negedge clk);
        i_core_val = 1'b0;
        i_net_data_val = 1'b0;
        #1;
        tests++;
        if (o_inject_cnt !== exp_inj || o_eject_cnt !== exp_ej || o_core_val !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset: got cnt=%0d/%0d val=%b want %0d/%0d val=1", o_inject_cnt, o_eject_cnt, o_core_val, exp_inj, exp_ej);
        end
        i_net_en = 1'b1;
        i_core_en = 1'b1;
        reset = 1'b1;
        #1;
        tests++;
        if ({o_core_en, o_net_en, o_net_data_val, o_core_val} !== 4'b0 || o_net_data !== '0 || o_core_data !== '0) begin
            fails++;
            $display("FAIL mid_reset: got flags=%b data=%h/%h want 0000 0/0", {o_core_en, o_net_en, o_net_data_val, o_core_val}, o_net_data, o_core_data);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_inj = '0;
        exp_ej = '0;
        #1;
        tests++;
        if (o_core_en !== 1'b1 || o_net_en !== 1'b1 || o_inject_cnt !== 32'd0 || o_eject_cnt !== 32'd0) begin
            fails++;
            $display("FAIL post_reset: got en=%b%b cnt=%0d/%0d want en=11 cnt=0/0", o_core_en, o_net_en, o_inject_cnt, o_eject_cnt);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            tests++;
            if (o_net_data_val !== 1'b0 || o_core_val !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_stale[%0d]: got vals=%b%b want 00", k, o_net_data_val, o_core_val);
            end
        end
    endtask

`ifdef ENOC_NI_DEST_CHECK_EN
    task automatic test_dest_check();
        i_core_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i_net_data_val = 1'b1;
            i_net_data = pk(k == 1 ? 9 : 3, 800 + k);
            #1;
            tests++;
            if (o_dest_err !== (k == 2) || o_net_en !== 1'b1) begin
                fails++;
                $display("FAIL dest_err[%0d]: got err=%b en=%b want err=%b en=1", k, o_dest_err, o_net_en, k == 2);
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i_net_data_val = 1'b0;
            i_core_en = k < 2;
            #1;
            tests++;
            if (o_dest_err !== 1'b1 || o_core_val !== (k < 2) ||
                (k < 2 && o_core_data !== pk(3, k == 0 ? 800 : 802))) begin
                fails++;
                $display("FAIL dest_drop[%0d]: got err=%b val=%b data=%h want err=1 val=%b data=%h", k, o_dest_err, o_core_val,
                         o_core_data, k < 2, pk(3, k == 0 ? 800 : 802));
            end
        end
        exp_ej += 2;
        tests++;
        if (o_eject_cnt !== exp_ej) begin
            fails++;
            $display("FAIL dest_cnt: got %0d want %0d", o_eject_cnt, exp_ej);
        end
    endtask
`else
    task automatic test_dest_check();
        i_core_en = 1'b0;
        @(negedge clk);
        i_net_data_val = 1'b1;
        i_net_data = pk(9, 900);
        @(negedge clk);
        i_net_data_val = 1'b0;
        i_core_en = 1'b1;
        #1;
        tests++;
        if (o_core_val !== 1'b1 || o_core_data !== pk(9, 900) || o_dest_err !== 1'b0) begin
            fails++;
            $display("FAIL no_dest_check: got val=%b data=%h err=%b want val=1 data=%h err=0", o_core_val, o_core_data, o_dest_err, pk(9, 900));
        end
        @(negedge clk);
        i_core_en = 1'b0;
        #1;
        exp_ej += 1;
        tests++;
        if (o_core_val !== 1'b0 || o_dest_err !== 1'b0 || o_eject_cnt !== exp_ej) begin
            fails++;
            $display("FAIL no_dest_check_after: got val=%b err=%b cnt=%0d want val=0 err=0 cnt=%0d", o_core_val, o_dest_err, o_eject_cnt, exp_ej);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_inject_order();
        test_inject_full();
        test_eject_full();
        test_back_to_back();
        test_reset_mid();
        test_dest_check();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
